// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Two-master arbiter sharing one single-port memory bus between an
// instruction-fetch port (i_*) and a load/store port (d_*). One transaction
// is in flight at a time. Each transaction passes through four states:
//   IDLE  -> grant a requester and latch its address, write data and operation
//   ISSUE -> one-cycle mem_ren / mem_wen strobe
//   WAIT  -> hold the address and data until mem_busy drops, or until the
//            WAIT-cycle budget (TIMEOUT) runs out
//   DONE  -> one-cycle ready pulse to the granted requester only
// When both masters request in the same IDLE cycle, the data port wins.
//
// Parameters
//   ADDR_W   address width of every address port
//   DATA_W   width of every data port
//   TIMEOUT  maximum number of WAIT cycles per transaction
//
// Ports
//   CLK, nRST            rising-edge clock, asynchronous active-low reset
//   i_ren, i_addr        instruction fetch request, held until i_ready
//   i_rdata, i_ready     fetched word (valid with i_ready) and completion pulse
//   d_ren, d_wen         data read / write request, held until d_ready
//   d_addr, d_wdata      data address and store data
//   d_rdata, d_ready     load data (valid with d_ready) and completion pulse
//   mem_ren, mem_wen     shared-bus read / write strobes
//   mem_addr, mem_wdata  shared-bus address and write data
//   mem_rdata, mem_busy  shared-bus read data and busy indication
//   bus_err              sticky timeout flag, cleared only by reset

module memory_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction port
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // data port
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // shared memory bus
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  // status
  output logic              bus_err
);

  // A zero budget would never let a transaction finish; treat it as one cycle.
  localparam int unsigned TimeoutEff = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned CntW       = $clog2(TimeoutEff + 1);
  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutEff - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              wr_q,      wr_d;      // latched operation: 1 = write
  logic              gnt_dat_q, gnt_dat_d; // 1 = data port owns the transaction
  logic [CntW-1:0]   cnt_q,     cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    gnt_dat_d = gnt_dat_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    bus_err_d = bus_err_q;

    case (state_q)
      IDLE: begin
        if (d_ren || d_wen) begin
          // Data port wins a tie; a simultaneous read+write is a write.
          gnt_dat_d = 1'b1;
          wr_d      = d_wen;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          state_d   = ISSUE;
        end else if (i_ren) begin
          gnt_dat_d = 1'b0;
          wr_d      = 1'b0;
          addr_d    = i_addr;
          wdata_d   = '0;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!mem_busy) begin
          // Completion wins over timeout when both happen in the same cycle.
          if (!wr_q) begin
            if (gnt_dat_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = mem_rdata;
            end
          end
          state_d = DONE;
        end else if (cnt_q == CntLast) begin
          bus_err_d = 1'b1;
          if (gnt_dat_q) begin
            d_rdata_d = '0;
          end else begin
            i_rdata_d = '0;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      gnt_dat_q <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      gnt_dat_q <= gnt_dat_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    mem_ren   = (state_q == ISSUE) && !wr_q;
    mem_wen   = (state_q == ISSUE) &&  wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ready   = (state_q == DONE) && !gnt_dat_q;
    d_ready   = (state_q == DONE) &&  gnt_dat_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    bus_err   = bus_err_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          CLK;
  logic          nRST;
  logic          i_ren;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_ren;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_busy;
  logic          bus_err;

  memory_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_ren    (i_ren),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ready  (i_ready),
    .d_ren    (d_ren),
    .d_wen    (d_wen),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_busy (mem_busy),
    .bus_err  (bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: what each requester should currently see.
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic          exp_err     = 1'b0;

  // One complete transaction. Entered and left at a falling edge with the DUT idle.
  // nbusy: number of WAIT cycles during which mem_busy stays high.
  task automatic run_txn(input logic ir, input logic dr, input logic dw,
                         input logic [AW-1:0] ia, input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, input int nbusy,
                         input logic [DW-1:0] rd, input bit perturb,
                         input int exp_cycles, input string tag);
    logic          data_win;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic          timed_out;
    int            exp_wait;
    int            k;
    bit            got;
    data_win  = dr | dw;
    exp_wr    = dw;
    exp_addr  = data_win ? da : ia;
    timed_out = (nbusy >= int'(TO));
    exp_wait  = timed_out ? int'(TO) : nbusy + 1;

    i_ren = ir; d_ren = dr; d_wen = dw;
    i_addr = ia; d_addr = da; d_wdata = dwd;
    mem_busy = 1'b1; mem_rdata = $urandom;

    // ISSUE
    @(posedge CLK); @(negedge CLK);
    n_total++;
    if ({mem_ren, mem_wen, i_ready, d_ready} !== {~exp_wr, exp_wr, 2'b00})
      $display("FAIL %s issue strobes: got ren/wen/ir/dr=%b required %b", tag,
               {mem_ren, mem_wen, i_ready, d_ready}, {~exp_wr, exp_wr, 2'b00});
    else n_pass++;
    n_total++;
    if (mem_addr !== exp_addr)
      $display("FAIL %s issue addr: got %h required %h", tag, mem_addr, exp_addr);
    else n_pass++;
    if (exp_wr) begin
      n_total++;
      if (mem_wdata !== dwd)
        $display("FAIL %s issue wdata: got %h required %h", tag, mem_wdata, dwd);
      else n_pass++;
    end

    // WAIT: observe until a ready pulse, bounded.
    k = 0; got = 0;
    while (!got && k < 40) begin
      if (perturb) begin
        i_ren = 1'($urandom); d_ren = 1'($urandom); d_wen = 1'($urandom);
        d_addr = da + 32'h40; i_addr = ~ia; d_wdata = $urandom;
      end
      @(posedge CLK); @(negedge CLK);
      if (i_ready || d_ready) begin
        got = 1;
      end else begin
        k++;
        n_total++;
        if ({mem_ren, mem_wen} !== 2'b00 || mem_addr !== exp_addr ||
            (exp_wr && mem_wdata !== dwd))
          $display("FAIL %s wait hold (cycle %0d): got ren/wen=%b addr=%h required 00 addr=%h",
                   tag, k, {mem_ren, mem_wen}, mem_addr, exp_addr);
        else n_pass++;
        mem_busy  = (k <= nbusy);
        mem_rdata = (k <= nbusy) ? $urandom : rd;
      end
    end

    n_total++;
    if (!got || k != exp_wait)
      $display("FAIL %s wait length: got %0d cycles (ready seen=%0d) required %0d",
               tag, k, got, exp_wait);
    else n_pass++;
    if (exp_cycles >= 0) begin
      n_total++;
      if (k + 3 != exp_cycles)
        $display("FAIL %s latency: got %0d required %0d", tag, k + 3, exp_cycles);
      else n_pass++;
    end

    // DONE
    if (timed_out) begin
      exp_err = 1'b1;
      if (data_win) exp_d_rdata = '0; else exp_i_rdata = '0;
    end else if (!exp_wr) begin
      if (data_win) exp_d_rdata = rd; else exp_i_rdata = rd;
    end
    n_total++;
    if ({i_ready, d_ready, mem_ren, mem_wen} !== {~data_win, data_win, 2'b00})
      $display("FAIL %s done ready: got ir/dr/ren/wen=%b required %b", tag,
               {i_ready, d_ready, mem_ren, mem_wen}, {~data_win, data_win, 2'b00});
    else n_pass++;
    n_total++;
    if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata || bus_err !== exp_err)
      $display("FAIL %s done data: got i=%h d=%h err=%b required i=%h d=%h err=%b", tag,
               i_rdata, d_rdata, bus_err, exp_i_rdata, exp_d_rdata, exp_err);
    else n_pass++;

    i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0; mem_busy = 1'b0;

    // Back in IDLE: no pulses, read data held.
    @(posedge CLK); @(negedge CLK);
    n_total++;
    if ({i_ready, d_ready, mem_ren, mem_wen} !== 4'b0000 || i_rdata !== exp_i_rdata ||
        d_rdata !== exp_d_rdata || bus_err !== exp_err)
      $display("FAIL %s idle hold: got ir/dr/ren/wen=%b i=%h d=%h err=%b required 0000 i=%h d=%h err=%b",
               tag, {i_ready, d_ready, mem_ren, mem_wen}, i_rdata, d_rdata, bus_err,
               exp_i_rdata, exp_d_rdata, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    i_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_busy = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_total++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata, mem_ren, mem_wen, i_ready, d_ready, bus_err}
        !== '0)
      $display("FAIL reset outputs: got addr=%h wdata=%h i=%h d=%h ren/wen/ir/dr/err=%b required all 0",
               mem_addr, mem_wdata, i_rdata, d_rdata,
               {mem_ren, mem_wen, i_ready, d_ready, bus_err});
    else n_pass++;
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    n_total++;
    if ({mem_ren, mem_wen, i_ready, d_ready, bus_err} !== 5'b0)
      $display("FAIL reset idle: got ren/wen/ir/dr/err=%b required 00000",
               {mem_ren, mem_wen, i_ready, d_ready, bus_err});
    else n_pass++;
  endtask

  task automatic test_fetch();
    run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 2, 32'h00A00093, 1'b0, 6, "fetch");
  endtask

  task automatic test_collision();
    run_txn(1'b1, 1'b0, 1'b1, 32'h300, 32'h2000, 32'hDEADBEEF, 1, 32'h5555AAAA, 1'b0, -1,
            "collide_store");
    run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h2000, 32'h0, 0, 32'h12345678, 1'b0, 4,
            "collide_fetch");
  endtask

  task automatic test_rw_both();
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h1234, 32'hCAFEF00D, 1, 32'h77777777, 1'b0, -1,
            "rw_both");
  endtask

  task automatic test_addr_change();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 3, 32'hA5A5A5A5, 1'b1, -1, "addr_change");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h0, 30, 32'hFFFFFFFF, 1'b0, 11, "timeout");
    // Sticky: a later clean transaction leaves bus_err set.
    run_txn(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 0, 32'h0BADF00D, 1'b0, 4, "after_timeout");
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    i_ren = 1'b0; d_ren = 1'b1; d_wen = 1'b0; d_addr = 32'h700; mem_busy = 1'b1;
    @(posedge CLK); @(negedge CLK);  // ISSUE
    @(posedge CLK); @(negedge CLK);  // WAIT
    #2 nRST = 1'b0;
    #1;
    exp_i_rdata = '0; exp_d_rdata = '0; exp_err = 1'b0;
    n_total++;
    if ({mem_addr, mem_wdata, i_rdata, d_rdata, mem_ren, mem_wen, i_ready, d_ready, bus_err}
        !== '0)
      $display("FAIL midwait reset outputs: got addr=%h wdata=%h i=%h d=%h ren/wen/ir/dr/err=%b required all 0",
               mem_addr, mem_wdata, i_rdata, d_rdata,
               {mem_ren, mem_wen, i_ready, d_ready, bus_err});
    else n_pass++;
    d_ren = 1'b0; mem_busy = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (i_ready || d_ready || mem_ren || mem_wen) seen = 1;
    end
    n_total++;
    if (seen)
      $display("FAIL midwait no_activity: got activity=1 required 0");
    else n_pass++;
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h704, 32'h0, 1, 32'h13572468, 1'b0, 5, "after_reset");
  endtask

  task automatic test_random();
    logic [2:0] r;
    for (int n = 0; n < 40; n++) begin
      r = 3'($urandom_range(1, 7));
      run_txn(r[0], r[1], r[2], $urandom, $urandom, $urandom,
              int'($urandom_range(0, 9)), $urandom, 1'($urandom), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_rw_both();
    test_addr_change();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
